mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single variable-latency RAM port between the instruction fetch path (read-only)
//  and the data path (read/write). Latches one request at a time and holds RAM address/data/
//  enables stable until ramstate reports ACCESS. Alternates grants when both paths contend,
//  and bounds every transaction with a timeout. Sits between the caches and ram.
// PARAMETERS
//  TIMEOUT  64            max cycles in a grant state without ACCESS before abort (>=LAT+2)
//  BADWORD  32'hBAD1BAD1  load value returned on abort/error
// PORTS
//  CLK       in   1   clock, all state on posedge
//  RST       in   1   reset: synchronous, active-high
//  iREN      in   1   instruction read request, held high until iwait low
//  iaddr     in   32  instruction word address
//  iload     out  32  instruction read data, valid when iREN & !iwait
//  iwait     out  1   instruction request not yet complete
//  ierr      out  1   one-cycle pulse: instruction access aborted
//  dREN      in   1   data read request
//  dWEN      in   1   data write request (wins if dREN also high)
//  daddr     in   32  data word address
//  dstore    in   32  data write value
//  dload     out  32  data read data, valid when dREN & !dwait
//  dwait     out  1   data request not yet complete
//  derr      out  1   one-cycle pulse: data access aborted
//  ramREN    out  1   to RAM
//  ramWEN    out  1   to RAM
//  ramaddr   out  32  to RAM, registered
//  ramstore  out  32  to RAM, registered
//  ramload   in   32  from RAM
//  ramstate  in   2   ramstate_t from RAM: FREE/BUSY/ACCESS/ERROR
// BEHAVIOUR
//  - States: IDLE, GNT_I, GNT_D. Registers: state, last (owner last served), lat_addr,
//    lat_data, lat_wen, tcnt.
//  - Reset (RST high at posedge): state=IDLE, last=I (first contention goes to D), tcnt=0,
//    lat_* = 0. ramREN=ramWEN=0 from next cycle. ierr=derr=0.
//  - IDLE: only D pending -> GNT_D. Only I pending -> GNT_I. Both pending -> the one != last.
//    On grant, latch addr/store/wen from the winner. tcnt=0.
//  - Grant latency: request sampled in IDLE at edge N. RAM enables are asserted in cycle N+1.
//  - GNT_x: ramREN=!lat_wen, ramWEN=lat_wen, ramaddr=lat_addr, ramstore=lat_data.
//    Outputs depend only on registers; no combinational path from requester to RAM.
//  - Completion: in GNT_x with ramstate==ACCESS, x_wait=0 and x_load=ramload in the same
//    cycle. Next state=IDLE, last=x. The requester sees exactly one cycle of wait low.
//  - Wait: iwait = iREN & !(state==GNT_I & ramstate==ACCESS). dwait is analogous with
//    (dREN|dWEN). A non-owner always waits.
//  - Loads: x_load = BADWORD whenever not completing.
//  - Abort: in GNT_x, an abort occurs if ramstate==ERROR, or tcnt==TIMEOUT-1 without ACCESS.
//    -> IDLE, last=x, x_err pulses 1 cycle, x_wait=0 that cycle, x_load=BADWORD.
//    ACCESS in the same cycle as timeout expiry counts as completion, not abort.
//  - Withdraw: owner drops its request while granted -> IDLE next edge. No response, no err.
//    RAM enables drop with the state change.
//  - Data changes addr/op mid-grant: ignored (the latched copy is used). The requester must
//    hold its request until wait is low.
//  - tcnt saturates at TIMEOUT-1 and is cleared on every entry to a grant state.
//  - Mid-transaction reset: RST overrides everything. No completion or err is produced for
//    the killed transaction.
//  - There is always an IDLE cycle between transactions. This guarantees RAM sees enables
//    low and restarts its latency count.
// STRUCTURE
//  - cpu_types_pkg gains: arb_state_t {IDLE,GNT_I,GNT_D} and owner_t {OWN_I,OWN_D}.
//    It already provides word_t and ramstate_t.
//  - BADWORD default lives in the package as constant ARB_BAD.
//  - Single flat module. Grant selection and timeout counter are inline. No sub-module.
// TESTING (bench drives the real ram model with LAT=10)
//  1 iREN=1, iaddr=0x40 alone -> ramREN=1 from cycle 1, iwait low exactly once at cycle 11,
//    iload=mem[0x40].
//  2 dWEN=1, daddr=0x80, dstore=0xCAFEF00D, then dREN on 0x80 -> write completes,
//    read returns 0xCAFEF00D.
//  3 iREN and dREN both high from reset, held -> D served first, then I, then D.
//    Grants alternate with one IDLE between each.
//  4 ram model forced to never ACCESS (or ramstate=ERROR) with dREN=1 -> after TIMEOUT
//    cycles derr=1 for 1 cycle, dwait=0, dload=0xBAD1BAD1.
//  5 dREN dropped at cycle 5 of grant -> IDLE next edge, no derr. Pending iREN granted next.
//  6 RST pulsed during GNT_D at cycle 4 -> ramREN/ramWEN=0 next cycle, state IDLE,
//    no completion, D granted first afterwards.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and memory arbiter types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam word_t ARB_BAD = 32'hBAD1BAD1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency RAM port between instruction fetch and data paths
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter word_t BADWORD = ARB_BAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  output logic        ierr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        derr,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  arb_state_t state, nstate;
  owner_t last;
  word_t lat_addr, lat_data;
  logic lat_wen;
  logic [TW-1:0] tcnt;
  logic gnt_i, gnt_d, acc, oreq, abort, pick_d, pick_i;
  always_comb begin
    gnt_i = state == GNT_I;
    gnt_d = state == GNT_D;
    acc = ramstate == ACCESS;
    oreq = gnt_i ? iREN : dREN | dWEN;
    abort = (gnt_i | gnt_d) & oreq & !acc & (ramstate == ERROR | tcnt == TMAX);
    pick_d = (dREN | dWEN) & (!iREN | last == OWN_I);
    pick_i = iREN & !pick_d;
    nstate = state == IDLE ? (pick_d ? GNT_D : pick_i ? GNT_I : IDLE)
           : (!(gnt_i | gnt_d) | acc | abort | !oreq) ? IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last <= OWN_I;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wen <= 1'b0;
      tcnt <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && nstate != IDLE) begin
        lat_addr <= pick_d ? daddr : iaddr;
        lat_data <= pick_d ? dstore : '0;
        lat_wen <= pick_d & dWEN;
      end
      if (state != IDLE && nstate == IDLE) last <= gnt_i ? OWN_I : OWN_D;
      // zero throughout IDLE, so every grant starts counting from 0
      tcnt <= state == IDLE ? '0 : tcnt == TMAX ? tcnt : tcnt + 1'b1;
    end
  end
  assign ramREN = (gnt_i | gnt_d) & !lat_wen;
  assign ramWEN = (gnt_i | gnt_d) & lat_wen;
  assign ramaddr = lat_addr;
  assign ramstore = lat_data;
  assign iload = gnt_i & acc ? ramload : BADWORD;
  assign dload = gnt_d & acc ? ramload : BADWORD;
  assign iwait = iREN & !(gnt_i & (acc | abort));
  assign dwait = (dREN | dWEN) & !(gnt_d & (acc | abort));
  assign ierr = gnt_i & abort;
  assign derr = gnt_d & abort;
endmodule
